add_round_key_unit: RTL and testbench

Registered AES AddRoundKey stage with an on-chip round-key store. The unit holds up to 11 round keys (AES-128, rounds 0..10). Each accepted 128-bit state is XORed with the key selected by its round index. It sits between the shiftRows/mixColumns datapath and the next round's input, and uses a valid/ready handshake on both sides.

---
 rtl/add_round_key_unit_if.sv | 37 +++
 rtl/add_round_key_unit.sv | 142 ++++++++++++++
 tb/tb_add_round_key_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_unit_if.sv
// Handshake and key-write bundle for add_round_key_unit; slave = the unit, master = its driver.
// Signal names and bit ordering ([0:DATA_W-1], byte 0 = bits 0:7) match the unit's datapath.
interface add_round_key_unit_if #(
    parameter int NUM_KEYS = 11,
    parameter int DATA_W   = 128,
    parameter int IDX_W    = $clog2(NUM_KEYS)
);
    logic               key_we;
    logic [IDX_W-1:0]   key_waddr;
    logic [0:DATA_W-1]  key_wdata;

    logic               in_valid;
    logic               in_ready;
    logic [IDX_W-1:0]   in_round;
    logic [0:DATA_W-1]  in_data;

    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_round;
    logic [0:DATA_W-1]  out_data;

    logic               key_err;

    modport master (
        output key_we, key_waddr, key_wdata,
        output in_valid, in_round, in_data,
        output out_ready,
        input  in_ready, out_valid, out_round, out_data, key_err
    );

    modport slave (
        input  key_we, key_waddr, key_wdata,
        input  in_valid, in_round, in_data,
        input  out_ready,
        output in_ready, out_valid, out_round, out_data, key_err
    );
endinterface

// File: rtl/add_round_key_unit.sv
// AES AddRoundKey stage with an 11-slot round-key store; optional zeroize port under ARK_ZEROIZE_EN.
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: output register plus 1-entry skid; in_ready is the registered "skid empty" flag.
module add_round_key_unit #(
    parameter int NUM_KEYS = 11,
    parameter int DATA_W   = 128
) (
    input  logic clk,
    input  logic n_rst,
`ifdef ARK_ZEROIZE_EN
    input  logic zeroize,
`endif
    add_round_key_unit_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_KEYS);

    logic [0:DATA_W-1]  key_mem_q [NUM_KEYS];
    logic [0:DATA_W-1]  key_mem_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] written_q, written_d;

    logic               out_valid_q, out_valid_d;
    logic [0:DATA_W-1]  out_data_q,  out_data_d;
    logic [IDX_W-1:0]   out_round_q, out_round_d;

    logic               skid_valid_q, skid_valid_d;
    logic [0:DATA_W-1]  skid_data_q,  skid_data_d;
    logic [IDX_W-1:0]   skid_round_q, skid_round_d;

    logic               key_err_q, key_err_d;

    logic               accept;
    logic               slot_written;
    logic               bypass;
    logic               lookup_err;
    logic [0:DATA_W-1]  key_sel;
    logic [0:DATA_W-1]  key_use;
    logic [0:DATA_W-1]  result;

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_round = out_round_q;
    assign bus.key_err   = key_err_q;

`ifdef ARK_ZEROIZE_EN
    assign accept = bus.in_valid && !skid_valid_q && !zeroize;
`else
    assign accept = bus.in_valid && !skid_valid_q;
`endif

    // Key lookup; an out-of-range round matches no slot, so it XORs with zero and flags an error.
    always_comb begin
        key_sel      = '0;
        slot_written = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (bus.in_round == IDX_W'(i)) begin
                key_sel      = key_mem_q[i];
                slot_written = written_q[i];
            end
        end
        bypass     = bus.key_we && (bus.key_waddr == bus.in_round) &&
                     (int'(bus.key_waddr) < NUM_KEYS);
        key_use    = bypass ? bus.key_wdata : (slot_written ? key_sel : '0);
        lookup_err = !(bypass || slot_written);
        result     = bus.in_data ^ key_use;
    end

    always_comb begin
        key_mem_d = key_mem_q;
        written_d = written_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (bus.key_we && (bus.key_waddr == IDX_W'(i))) begin
                key_mem_d[i] = bus.key_wdata;
                written_d[i] = 1'b1;
            end
        end

        key_err_d = key_err_q | (accept && lookup_err);

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_round_d  = out_round_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_round_d = skid_round_q;

        if (!out_valid_q || bus.out_ready) begin
            // Output slot frees up: a parked skid entry always goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_round_d  = skid_round_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = result;
                out_round_d = bus.in_round;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = result;
            skid_round_d = bus.in_round;
        end

`ifdef ARK_ZEROIZE_EN
        if (zeroize) begin
            for (int i = 0; i < NUM_KEYS; i++) key_mem_d[i] = '0;
            written_d    = '0;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_mem_q    <= '{default: '0};
            written_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_round_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_round_q <= '0;
            key_err_q    <= 1'b0;
        end else begin
            key_mem_q    <= key_mem_d;
            written_q    <= written_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_round_q  <= out_round_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_round_q <= skid_round_d;
            key_err_q    <= key_err_d;
        end
    end
endmodule

// File: tb/tb_add_round_key_unit.sv
// Randomised and directed bench for add_round_key_unit with a queue-based scoreboard.
module tb_add_round_key_unit;
    localparam int NUM_KEYS = 11;

    typedef struct {
        logic [3:0]   rnd;
        logic [0:127] dat;
    } exp_t;

    logic clk;
    logic n_rst;
    add_round_key_unit_if #(.NUM_KEYS(NUM_KEYS), .DATA_W(128)) bus ();

    add_round_key_unit #(.NUM_KEYS(NUM_KEYS), .DATA_W(128)) dut (
        .clk   (clk),
        .n_rst (n_rst),
`ifdef ARK_ZEROIZE_EN
        .zeroize (1'b0),
`endif
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t         exp_q[$];
    logic [0:127] m_key [16];
    bit           m_wr  [16];
    bit           exp_err_now;
    bit           exp_err_next;
    bit           drv_accept;
    int           mon_occ;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.key_we    = 1'b0;
        bus.key_waddr = '0;
        bus.key_wdata = '0;
        bus.in_valid  = 1'b0;
        bus.in_round  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_key[i] = '0;
            m_wr[i]  = 1'b0;
        end
        exp_q.delete();
        exp_err_now  = 1'b0;
        exp_err_next = 1'b0;
        drv_accept   = 1'b0;
    endtask

    task automatic assert_reset();
        n_rst = 1'b0;
        idle_inputs();
        clear_model();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        n_rst = 1'b1;
    endtask

    // One clock of stimulus; the reference model applies this cycle's key write before the
    // lookup, which is exactly the write-through behaviour a same-slot read must see.
    task automatic cycle(input bit we, input int waddr, input logic [0:127] wdata,
                         input bit iv, input int rnd, input logic [0:127] dat, input bit ordy);
        logic [0:127] k;
        bit           ok;
        @(posedge clk);
        #1;
        exp_err_now   = exp_err_next;
        bus.key_we    = we;
        bus.key_waddr = 4'(waddr);
        bus.key_wdata = wdata;
        bus.in_valid  = iv;
        bus.in_round  = 4'(rnd);
        bus.in_data   = dat;
        bus.out_ready = ordy;
        if (we && waddr < NUM_KEYS) begin
            m_key[waddr] = wdata;
            m_wr[waddr]  = 1'b1;
        end
        drv_accept = iv && bus.in_ready;
        if (drv_accept) begin
            ok = (rnd < NUM_KEYS) && m_wr[rnd];
            k  = ok ? m_key[rnd] : '0;
            exp_q.push_back('{rnd: 4'(rnd), dat: dat ^ k});
            if (!ok) exp_err_next = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, '0, 0, 0, '0, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d results still outstanding, required 0", name, exp_q.size());
        end
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        chk({name, "_idle_out_valid"}, 128'(bus.out_valid), 128'(0));
    endtask

    // Monitor: key_err and in_ready against the model, then pop on every output handshake.
    always @(negedge clk) begin
        if (n_rst) begin
            chk("key_err", 128'(bus.key_err), 128'(exp_err_now));
            mon_occ = exp_q.size() - (drv_accept ? 1 : 0);
            chk("in_ready", 128'(bus.in_ready), 128'(mon_occ < 2));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got round %0d data %h, required no output",
                             bus.out_round, bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.dat);
                    chk("out_round", 128'(bus.out_round), 128'(e.rnd));
                end
            end
        end
    end

    initial begin
        logic [0:127] d;
        assert_reset();
        #2;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data",  bus.out_data, 128'(0));
        chk("rst_out_round", 128'(bus.out_round), 128'(0));
        chk("rst_key_err",   128'(bus.key_err), 128'(0));
        chk("rst_in_ready",  128'(bus.in_ready), 128'(1));
        release_reset();

        // Known-answer AES round-1 AddRoundKey.
        cycle(1, 1, 128'ha0fafe1788542cb123a339392a6c7605, 0, 0, '0, 1);
        cycle(0, 0, '0, 1, 1, 128'h046681e5e0cb199a48f8d37a2806264c, 1);
        drain("kat");

        // Back-to-back, four consecutive rounds.
        cycle(1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, '0, 1);
        cycle(1, 3, 128'h3d80477d4716fe3e1e237e446d7a883b, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, '0, 1, i % 4, {4{$urandom}}, 1);
        drain("b2b");

        // Backpressure: three stalled cycles with input offered, then release.
        for (int i = 0; i < 3; i++)
            cycle(0, 0, '0, 1, i % 2, {4{$urandom}}, 0);
        for (int i = 0; i < 3; i++)
            cycle(0, 0, '0, 0, 0, '0, 1);
        drain("bp");

        // Same-cycle write and read of slot 2.
        cycle(1, 2, {128{1'b1}}, 1, 2, '0, 1);
        drain("wt");

        // Out-of-range round passes data through and sets the sticky error.
        cycle(0, 0, '0, 1, 12, 128'h0123456789abcdef0123456789abcdef, 1);
        drain("oor");
        cycle(0, 0, '0, 1, 0, {4{$urandom}}, 1);
        drain("sticky");

        // Reset in the middle of backpressure.
        cycle(0, 0, '0, 1, 1, {4{$urandom}}, 0);
        cycle(0, 0, '0, 1, 0, {4{$urandom}}, 0);
        @(negedge clk);
        #1;
        assert_reset();
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_out_data",  bus.out_data, 128'(0));
        chk("mid_rst_key_err",   128'(bus.key_err), 128'(0));
        release_reset();
        cycle(0, 0, '0, 1, 1, 128'h00112233445566778899aabbccddeeff, 1);
        drain("post_rst_slot1");

        // Unwritten slot 5 on its own.
        assert_reset();
        release_reset();
        cycle(1, 4, {4{$urandom}}, 0, 0, '0, 1);
        cycle(0, 0, '0, 1, 5, {4{$urandom}}, 1);
        drain("unwritten5");

        // Random traffic, including ignored out-of-range writes and random stalls.
        assert_reset();
        release_reset();
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom % 3) == 0, $urandom % 16, {$urandom, $urandom, $urandom, $urandom},
                  ($urandom % 4) != 0, $urandom % 13, d, ($urandom % 4) != 0);
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
